grb_frame_sequencer: RTL and testbench

GRB_FRAME_SEQUENCER -- requirements
Module: grb_frame_sequencer

---
 rtl/grb_frame_sequencer.sv | 139 +++++++++++++
 tb/tb_grb_frame_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/grb_frame_sequencer.sv
// grb_frame_sequencer: fetches one 24-bit {G,R,B} word per LED over a
// req/ack handshake and serialises it MSB first as WS2812 pulse-width bits,
// then holds the line low for the latch period and pulses done.
module grb_frame_sequencer #(
  parameter int NUM_LEDS     = 10,
  parameter int CLK_PER_BIT  = 63,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int LATCH_CYCLES = 2500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        pix_req,
  input  logic        pix_ack,
  input  logic [23:0] pix_data,
  output logic [3:0]  led_idx,
  output logic [7:0]  bits_sent,
  output logic        dout,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(CLK_PER_BIT + 1);
  localparam int LW = $clog2(LATCH_CYCLES + 1);

  localparam logic [CW-1:0] CYC_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HI0      = CW'(T0H);
  localparam logic [CW-1:0] HI1      = CW'(T1H);
  localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);
  localparam logic [3:0]    LED_LAST = 4'(NUM_LEDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

  state_t        state;
  logic [23:0]   shreg;
  logic [4:0]    bit_cnt;
  logic [CW-1:0] cyc;
  logic [LW-1:0] lat_cnt;

  logic [CW-1:0] cyc_nxt;
  logic          hi_nxt;

  // Level of the line for the next cycle inside the current bit period.
  always_comb begin
    cyc_nxt = cyc + 1'b1;
    hi_nxt  = cyc_nxt < (shreg[23] ? HI1 : HI0);
  end

  // Frame sequencer; every output is a register so dout is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pix_req   <= 1'b0;
      led_idx   <= '0;
      bits_sent <= '0;
      dout      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      cyc       <= '0;
      lat_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            pix_req   <= 1'b1;
            busy      <= 1'b1;
            led_idx   <= '0;
            bits_sent <= '0;
          end
        end
        FETCH: begin
          if (abort) begin
            state   <= LATCH;
            pix_req <= 1'b0;
            dout    <= 1'b0;
            lat_cnt <= '0;
            done    <= (LAT_LAST == '0);
          end else if (pix_ack) begin
            state   <= SEND;
            pix_req <= 1'b0;
            shreg   <= pix_data;
            bit_cnt <= '0;
            cyc     <= '0;
            dout    <= 1'b1;
          end
        end
        SEND: begin
          // Abort takes priority even on a bit's last cycle, so the
          // interrupted bit is never counted.
          if (abort) begin
            state   <= LATCH;
            dout    <= 1'b0;
            lat_cnt <= '0;
            done    <= (LAT_LAST == '0);
          end else if (cyc == CYC_LAST) begin
            bits_sent <= bits_sent + 1'b1;
            cyc       <= '0;
            if (bit_cnt == 5'd23) begin
              dout <= 1'b0;
              if (led_idx == LED_LAST) begin
                state   <= LATCH;
                lat_cnt <= '0;
                done    <= (LAT_LAST == '0);
              end else begin
                state   <= FETCH;
                led_idx <= led_idx + 1'b1;
                pix_req <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= {shreg[22:0], 1'b0};
              dout    <= 1'b1;
            end
          end else begin
            cyc  <= cyc_nxt;
            dout <= hi_nxt;
          end
        end
        LATCH: begin
          if (lat_cnt == LAT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
            done    <= ((lat_cnt + 1'b1) == LAT_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grb_frame_sequencer.sv
// Testbench for grb_frame_sequencer: whole-frame waveform traces compared
// against a timeline model built from the frame rules, plus table vectors,
// random frames and an asynchronous reset sequence.
module tb_grb_frame_sequencer;

  localparam int NL  = 2;
  localparam int CPB = 10;
  localparam int T0  = 3;
  localparam int T1  = 7;
  localparam int LC  = 20;

  logic        clk = 1'b0;
  logic        reset, start, abort, pix_ack;
  logic [23:0] pix_data;
  logic        pix_req, dout, busy, done;
  logic [3:0]  led_idx;
  logic [7:0]  bits_sent;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  grb_frame_sequencer #(
    .NUM_LEDS(NL), .CLK_PER_BIT(CPB), .T0H(T0), .T1H(T1), .LATCH_CYCLES(LC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .pix_req(pix_req), .pix_ack(pix_ack), .pix_data(pix_data),
    .led_idx(led_idx), .bits_sent(bits_sent), .dout(dout),
    .busy(busy), .done(done)
  );

  // One expected cycle of the frame timeline; ph: 0 fetch, 1 send, 2 latch, 3 idle.
  typedef struct {
    logic       dout, req, busy, done, ack;
    logic [3:0] led;
    logic [7:0] bits;
    int         ph;
  } samp_t;

  typedef struct {
    logic [23:0] p0, p1;
    int          d0, d1, ak;
    logic        sa, noise;
    logic [7:0]  eb;
    logic [3:0]  el;
  } vec_t;

  samp_t       exp_q[$];
  logic [23:0] px[NL];
  int          dly[NL];
  vec_t        vt[8];

  function automatic samp_t mk(logic d, logic r, logic b, logic dn, logic a,
                               logic [3:0] l, logic [7:0] bs, int ph);
    samp_t s;
    s.dout = d; s.req = r; s.busy = b; s.done = dn; s.ack = a;
    s.led = l; s.bits = bs; s.ph = ph;
    return s;
  endfunction

  function automatic samp_t grab();
    return mk(dout, pix_req, busy, done, 1'b0, led_idx, bits_sent, 0);
  endfunction

  function automatic logic same(samp_t a, samp_t e);
    return (a.dout === e.dout) && (a.req === e.req) && (a.busy === e.busy) &&
           (a.done === e.done) && (a.led === e.led) && (a.bits === e.bits);
  endfunction

  function automatic string fmt(samp_t s);
    return $sformatf("dout=%0b req=%0b busy=%0b done=%0b led=%0d bits=%0d",
                     s.dout, s.req, s.busy, s.done, s.led, s.bits);
  endfunction

  task automatic check(input string name, input logic ok, input string detail);
    checks++;
    if (ok === 1'b1) passed++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  task automatic push_tail(input logic [3:0] l, input logic [7:0] bs);
    for (int j = 0; j < LC; j++) exp_q.push_back(mk(0, 0, 1, j == LC - 1, 0, l, bs, 2));
    for (int j = 0; j < 3; j++)  exp_q.push_back(mk(0, 0, 0, 0, 0, l, bs, 3));
  endtask

  // Expected frame timeline: per LED (delay+1) request cycles then 24 bit
  // periods; an abort in fetch/send cuts the timeline short into the latch.
  task automatic build(input int abort_k);
    samp_t s;
    int    b;
    logic  bv;
    exp_q.delete();
    for (int i = 0; i < NL; i++) begin
      for (int f = 0; f <= dly[i]; f++)
        exp_q.push_back(mk(0, 1, 1, 0, f == dly[i], 4'(i), 8'(i * 24), 0));
      for (int c = 0; c < 24 * CPB; c++) begin
        b  = c / CPB;
        bv = px[i][23 - b];
        exp_q.push_back(mk((c % CPB) < (bv ? T1 : T0), 0, 1, 0, 0, 4'(i), 8'(i * 24 + b), 1));
      end
    end
    if (abort_k >= 0 && abort_k < exp_q.size() && exp_q[abort_k].ph <= 1) begin
      s = exp_q[abort_k];
      while (exp_q.size() > abort_k + 1) void'(exp_q.pop_back());
      push_tail(s.led, s.bits);
    end else begin
      push_tail(4'(NL - 1), 8'(NL * 24));
    end
  endtask

  // Starts a frame from IDLE (called at a negedge) and compares every cycle.
  task automatic run_frame(input string name, input int abort_k, input logic sa,
                           input logic noise, input int stop_k);
    samp_t a, e, bad_a, bad_e;
    int    bad = -1;
    int    n;
    build(abort_k);
    n = exp_q.size();
    if (stop_k >= 0 && stop_k < n) n = stop_k + 1;
    start = 1'b1; abort = sa; pix_ack = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a = grab();
      e = exp_q[k];
      if (bad < 0 && !same(a, e)) begin bad = k; bad_a = a; bad_e = e; end
      start = noise && (e.ph != 3) && ($urandom_range(0, 3) == 0);
      abort = (k == abort_k) || (noise && (e.ph == 2) && ($urandom_range(0, 2) == 0));
      if (e.ack) begin
        pix_ack = 1'b1; pix_data = px[e.led];
      end else if (noise && (e.ph != 0)) begin
        pix_ack = 1'($urandom_range(0, 1)); pix_data = 24'($urandom);
      end else begin
        pix_ack = 1'b0; pix_data = 24'($urandom);
      end
    end
    start = 1'b0; abort = 1'b0; pix_ack = 1'b0;
    check(name, bad < 0, bad < 0 ? "" :
          $sformatf("cycle %0d got %s, required %s", bad, fmt(bad_a), fmt(bad_e)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic ok;
    int   total, ak;
    reset = 1'b0; start = 1'b0; abort = 1'b0; pix_ack = 1'b0; pix_data = '0;

    vt[0] = '{24'hFF0000, 24'h000001, 0, 0,  -1, 1'b0, 1'b0, 8'd48, 4'd1};
    vt[1] = '{24'hFF0000, 24'h000001, 0, 5,  -1, 1'b0, 1'b1, 8'd48, 4'd1};
    vt[2] = '{24'hFF0000, 24'h000001, 0, 0,  94, 1'b0, 1'b0, 8'd9,  4'd0};
    vt[3] = '{24'h123456, 24'hABCDEF, 2, 3, 244, 1'b0, 1'b0, 8'd24, 4'd1};
    vt[4] = '{24'hA55A3C, 24'h0F0F0F, 1, 1,  -1, 1'b1, 1'b1, 8'd48, 4'd1};
    vt[5] = '{24'h800001, 24'h7FFFFE, 0, 0, 487, 1'b0, 1'b0, 8'd48, 4'd1};
    vt[6] = '{24'hFFFFFF, 24'h000000, 0, 0,  10, 1'b0, 1'b0, 8'd0,  4'd0};
    vt[7] = '{24'h000000, 24'hFFFFFF, 0, 0,   0, 1'b0, 1'b0, 8'd0,  4'd0};

    repeat (2) @(negedge clk);
    check("reset_state",
          {dout, pix_req, busy, done} === 4'b0 && led_idx === 4'd0 && bits_sent === 8'd0,
          $sformatf("got dout=%0b req=%0b busy=%0b done=%0b led=%0d bits=%0d, required all 0",
                    dout, pix_req, busy, done, led_idx, bits_sent));
    reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      px[0] = vt[v].p0; px[1] = vt[v].p1; dly[0] = vt[v].d0; dly[1] = vt[v].d1;
      run_frame($sformatf("vec%0d_trace", v), vt[v].ak, vt[v].sa, vt[v].noise, -1);
      check($sformatf("vec%0d_bits", v), bits_sent === vt[v].eb,
            $sformatf("got %0d, required %0d", bits_sent, vt[v].eb));
      check($sformatf("vec%0d_led", v), led_idx === vt[v].el,
            $sformatf("got %0d, required %0d", led_idx, vt[v].el));
    end

    for (int r = 0; r < 6; r++) begin
      px[0] = 24'($urandom); px[1] = 24'($urandom);
      dly[0] = $urandom_range(0, 4); dly[1] = $urandom_range(0, 4);
      total = dly[0] + dly[1] + 2 + 48 * CPB + LC;
      ak = ($urandom_range(0, 1) == 1) ? $urandom_range(0, total - 1) : -1;
      run_frame($sformatf("rand%0d_trace", r), ak, 1'($urandom_range(0, 1)), 1'b1, -1);
    end

    // Reset asserted between edges while dout is high in the first cycle of bit 3.
    px[0] = 24'hC3C3C3; px[1] = 24'h5A5A5A; dly[0] = 0; dly[1] = 0;
    run_frame("pre_reset_trace", -1, 1'b0, 1'b0, 31);
    #2 reset = 1'b0;
    #1 check("async_reset",
             {dout, pix_req, busy, done} === 4'b0 && led_idx === 4'd0 && bits_sent === 8'd0,
             $sformatf("got dout=%0b req=%0b busy=%0b done=%0b led=%0d bits=%0d, required all 0",
                       dout, pix_req, busy, done, led_idx, bits_sent));
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || dout !== 1'b0) ok = 1'b0;
    end
    check("held_in_reset", ok,
          $sformatf("got done=%0b busy=%0b dout=%0b, required 0", done, busy, dout));
    reset = 1'b1;
    run_frame("post_reset_trace", -1, 1'b0, 1'b0, -1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
